// File: rtl/servo_move_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : servo_move_scheduler
// Description : Arbitrates keyboard / autonomous grid move requests (keyboard
//               has fixed priority), converts the granted (x,y) cell into
//               servo pulse-width targets, slews X then Y in rate-limited
//               steps once per tick, settles, then pulses done.
// Revision    : 1.0 - initial release
// ============================================================================
module servo_move_scheduler #(
    parameter int X_MAX        = 4,
    parameter int Y_MAX        = 4,
    parameter int PW_MIN       = 1000,
    parameter int PW_GRID      = 250,
    parameter int RAMP_STEP    = 10,
    parameter int TICK_DIV     = 1000,
    parameter int SETTLE_TICKS = 50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        kb_valid,
    input  logic [7:0]  kb_x,
    input  logic [7:0]  kb_y,
    output logic        kb_ready,
    input  logic        auto_valid,
    input  logic [7:0]  auto_x,
    input  logic [7:0]  auto_y,
    output logic        auto_ready,
    output logic [15:0] pw_x,
    output logic [15:0] pw_y,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        grant_auto
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int SET_W  = $clog2(SETTLE_TICKS + 1);

    localparam logic [TICK_W-1:0] c_tick_last   = TICK_W'(TICK_DIV - 1);
    localparam logic [SET_W-1:0]  c_settle_last = SET_W'(SETTLE_TICKS - 1);
    localparam logic [7:0]        c_x_max       = 8'(X_MAX);
    localparam logic [7:0]        c_y_max       = 8'(Y_MAX);
    localparam logic [15:0]       c_pw_min      = 16'(PW_MIN);
    localparam logic [15:0]       c_pw_grid     = 16'(PW_GRID);
    localparam logic [15:0]       c_ramp        = 16'(RAMP_STEP);
    localparam logic [15:0]       c_home_x      = 16'(PW_MIN + 2 * PW_GRID);
    localparam logic [15:0]       c_home_y      = 16'(PW_MIN + 3 * PW_GRID);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MOVE_X = 2'd1,
        S_MOVE_Y = 2'd2,
        S_SETTLE = 2'd3
    } state_t;

    state_t              r_state;
    logic [TICK_W-1:0]   r_tick_cnt;
    logic [SET_W-1:0]    r_settle_cnt;
    logic [15:0]         r_pw_x;
    logic [15:0]         r_pw_y;
    logic [15:0]         r_tgt_x;
    logic [15:0]         r_tgt_y;
    logic                r_done;
    logic                r_err;
    logic                r_grant_auto;

    logic                w_idle;
    logic                w_xfer;
    logic [7:0]          w_req_x;
    logic [7:0]          w_req_y;
    logic                w_in_range;
    logic [15:0]         w_tgt_x;
    logic [15:0]         w_tgt_y;
    logic                w_tick;
    logic [TICK_W-1:0]   w_tick_next;

    // One rate-limited step toward the target; lands exactly on it when close.
    function automatic logic [15:0] f_step(input logic [15:0] cur, input logic [15:0] tgt);
        if (tgt > cur)
            return ((tgt - cur) <= c_ramp) ? tgt : (cur + c_ramp);
        else
            return ((cur - tgt) <= c_ramp) ? tgt : (cur - c_ramp);
    endfunction

    assign w_idle     = (r_state == S_IDLE);
    assign kb_ready   = w_idle;
    assign auto_ready = w_idle & ~kb_valid;
    assign w_xfer     = w_idle & (kb_valid | auto_valid);

    // Keyboard wins whenever it is valid; otherwise the auto source is taken.
    assign w_req_x    = kb_valid ? kb_x : auto_x;
    assign w_req_y    = kb_valid ? kb_y : auto_y;
    assign w_in_range = (w_req_x >= 8'd1) && (w_req_x <= c_x_max) &&
                        (w_req_y >= 8'd1) && (w_req_y <= c_y_max);
    assign w_tgt_x    = c_pw_min + (16'(w_req_x) - 16'd1) * c_pw_grid;
    assign w_tgt_y    = c_pw_min + (16'(w_req_y) - 16'd1) * c_pw_grid;

    assign w_tick      = (r_tick_cnt == c_tick_last);
    assign w_tick_next = w_tick ? '0 : (r_tick_cnt + TICK_W'(1));

    assign pw_x       = r_pw_x;
    assign pw_y       = r_pw_y;
    assign busy       = ~w_idle;
    assign done       = r_done;
    assign err        = r_err;
    assign grant_auto = r_grant_auto;

    // Move sequencer: accept, slew X, slew Y, settle, report.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_tick_cnt   <= '0;
            r_settle_cnt <= '0;
            r_pw_x       <= c_home_x;
            r_pw_y       <= c_home_y;
            r_tgt_x      <= c_home_x;
            r_tgt_y      <= c_home_y;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_grant_auto <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_tick_cnt <= '0;
                    if (w_xfer) begin
                        r_grant_auto <= ~kb_valid;
                        if (w_in_range) begin
                            r_tgt_x <= w_tgt_x;
                            r_tgt_y <= w_tgt_y;
                            r_state <= S_MOVE_X;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_MOVE_X: begin
                    // Arrival is checked before stepping so an axis at target costs one cycle.
                    if (r_pw_x == r_tgt_x) begin
                        r_state    <= S_MOVE_Y;
                        r_tick_cnt <= '0;
                    end else begin
                        r_tick_cnt <= w_tick_next;
                        if (w_tick)
                            r_pw_x <= f_step(r_pw_x, r_tgt_x);
                    end
                end
                S_MOVE_Y: begin
                    if (r_pw_y == r_tgt_y) begin
                        r_state      <= S_SETTLE;
                        r_tick_cnt   <= '0;
                        r_settle_cnt <= '0;
                    end else begin
                        r_tick_cnt <= w_tick_next;
                        if (w_tick)
                            r_pw_y <= f_step(r_pw_y, r_tgt_y);
                    end
                end
                S_SETTLE: begin
                    r_tick_cnt <= w_tick_next;
                    if (w_tick) begin
                        if (r_settle_cnt == c_settle_last) begin
                            r_state    <= S_IDLE;
                            r_tick_cnt <= '0;
                            r_done     <= 1'b1;
                        end else begin
                            r_settle_cnt <= r_settle_cnt + SET_W'(1);
                        end
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_tick_cnt <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
